vga_sync: RTL and testbench

- Timing generator that drives the VGA pixel-coordinate interface consumed by vga_frame: o_pix_valid, o_col, o_row.
- Also produces the monitor sync pins o_hsync and o_vsync.
- Derives the pixel rate from the system clock with an integer divider and runs the standard 640x480@60 counters.
- Delays the sync outputs by one clock so they line up with vga_frame's one-cycle-registered colour outputs.

---
 rtl/vga_sync.sv | 126 ++++++++++++
 tb/tb_vga_sync.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/vga_sync.sv
// VGA timing generator: divides clk down to the pixel rate, runs the
// horizontal/vertical counters, and produces registered pixel coordinates,
// a visible-area flag, a frame-start pulse and sync pins. The sync pins
// are one clk later than the coordinates to match a downstream colour
// register.
module vga_sync #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter int   CLK_DIV     = 4,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic       o_pix_valid,
    output logic [9:0] o_col,
    output logic [9:0] o_row,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST  = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST  = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    // Counters are 10 bits wide; larger timings cannot be represented.
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_params
        $error("vga_sync: unsupported parameters (H_TOTAL=%0d V_TOTAL=%0d CLK_DIV=%0d)",
               H_TOTAL, V_TOTAL, CLK_DIV);
    end

    logic [DIV_W-1:0] div_cnt;
    logic             pix_tick;
    logic [9:0]       hcnt;
    logic [9:0]       vcnt;
    logic             visible;
    logic             h_act;
    logic             v_act;
    logic             at_origin;
    logic             hsync_p0;
    logic             vsync_p0;

    assign pix_tick = (div_cnt == DIV_LAST);

    // Pixel-rate divider: wraps every CLK_DIV clocks (stays at 0 for CLK_DIV=1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (pix_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Raster counters: advance once per pixel tick; both wrap together at the frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_tick) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end
        end
    end

    // Stage p0 decode from the live counters.
    always_comb begin
        visible   = (hcnt < H_VIS) && (vcnt < V_VIS);
        h_act     = (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
        v_act     = (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);
        // div_cnt == 0 marks the first clk a new counter value is on the outputs.
        at_origin = (hcnt == 10'd0) && (vcnt == 10'd0) && (div_cnt == '0);
    end

    // Stage p0 -> outputs: coordinates, valid and frame start, plus the first sync stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_col         <= '0;
            o_row         <= '0;
            o_pix_valid   <= 1'b0;
            o_frame_start <= 1'b0;
            hsync_p0      <= ~SYNC_ACTIVE;
            vsync_p0      <= ~SYNC_ACTIVE;
        end else begin
            o_col         <= hcnt;
            o_row         <= vcnt;
            o_pix_valid   <= visible;
            o_frame_start <= at_origin;
            hsync_p0      <= h_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_p0      <= v_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

    // Stage p1: extra sync delay so the pins line up with registered colour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_hsync <= ~SYNC_ACTIVE;
            o_vsync <= ~SYNC_ACTIVE;
        end else begin
            o_hsync <= hsync_p0;
            o_vsync <= vsync_p0;
        end
    end

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: two small-geometry builds (CLK_DIV=3 with active-low
// sync, CLK_DIV=1 with active-high sync) compared cycle by cycle against a
// reference model driven from the number of edges since reset release.
module tb_vga_sync;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int DIV_A = 3;
    localparam int DIV_B = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       a_valid, a_hs, a_vs, a_fs;
    logic [9:0] a_col, a_row;
    logic       b_valid, b_hs, b_vs, b_fs;
    logic [9:0] b_col, b_row;

    always #5 clk = ~clk;

    vga_sync #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(DIV_A), .SYNC_ACTIVE(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .o_pix_valid(a_valid), .o_col(a_col), .o_row(a_row),
        .o_hsync(a_hs), .o_vsync(a_vs), .o_frame_start(a_fs)
    );

    vga_sync #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(DIV_B), .SYNC_ACTIVE(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .o_pix_valid(b_valid), .o_col(b_col), .o_row(b_row),
        .o_hsync(b_hs), .o_vsync(b_vs), .o_frame_start(b_fs)
    );

    typedef struct {
        int col;
        int row;
        int valid;
        int fs;
        int hs;
        int vs;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Expected outputs after edge t (t=1 is the first edge after release).
    function automatic exp_t model(input int t, input int div, input int sa);
        exp_t e;
        int p, pp, pc, pr;
        p       = (t - 1) / div;
        e.col   = p % HT;
        e.row   = (p / HT) % VT;
        e.valid = (e.col < HV && e.row < VV) ? 1 : 0;
        e.fs    = (((t - 1) % (div * HT * VT)) == 0) ? 1 : 0;
        e.hs    = 1 - sa;
        e.vs    = 1 - sa;
        if (t >= 2) begin
            pp = (t - 2) / div;
            pc = pp % HT;
            pr = (pp / HT) % VT;
            if (pc >= HV + HF && pc < HV + HF + HS) e.hs = sa;
            if (pr >= VV + VF && pr < VV + VF + VS) e.vs = sa;
        end
        return e;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, " a_col"},   int'(a_col), 0);
        check({tag, " a_row"},   int'(a_row), 0);
        check({tag, " a_valid"}, int'(a_valid), 0);
        check({tag, " a_fs"},    int'(a_fs), 0);
        check({tag, " a_hs"},    int'(a_hs), 1);
        check({tag, " a_vs"},    int'(a_vs), 1);
        check({tag, " b_col"},   int'(b_col), 0);
        check({tag, " b_row"},   int'(b_row), 0);
        check({tag, " b_valid"}, int'(b_valid), 0);
        check({tag, " b_fs"},    int'(b_fs), 0);
        check({tag, " b_hs"},    int'(b_hs), 0);
        check({tag, " b_vs"},    int'(b_vs), 0);
    endtask

    // Free-run n clocks after a release; push expectations at each edge, compare at the falling edge.
    task automatic run(input int n);
        exp_t ea, eb;
        int   t;
        t = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            t++;
            qa.push_back(model(t, DIV_A, 0));
            qb.push_back(model(t, DIV_B, 1));
            @(negedge clk);
            ea = qa.pop_front();
            eb = qb.pop_front();
            check("a_col",   int'(a_col),   ea.col);
            check("a_row",   int'(a_row),   ea.row);
            check("a_valid", int'(a_valid), ea.valid);
            check("a_fs",    int'(a_fs),    ea.fs);
            check("a_hs",    int'(a_hs),    ea.hs);
            check("a_vs",    int'(a_vs),    ea.vs);
            check("b_col",   int'(b_col),   eb.col);
            check("b_row",   int'(b_row),   eb.row);
            check("b_valid", int'(b_valid), eb.valid);
            check("b_fs",    int'(b_fs),    eb.fs);
            check("b_hs",    int'(b_hs),    eb.hs);
            check("b_vs",    int'(b_vs),    eb.vs);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("init");
        rst = 1'b0;

        // Two full frames of dut_a plus part of a third (mid-frame for both builds).
        run(2 * DIV_A * HT * VT + 200);

        // Asynchronous reset between edges: outputs must clear without a clock.
        #1 rst = 1'b1;
        #1 check_reset("async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("held");
        rst = 1'b0;

        run(DIV_A * HT * VT + 30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
